// File: rtl/aes_block_serializer_ctrl.sv
// aes_block_serializer_ctrl
// Sequencing controller for the 128-to-32 output shift register of the AES128
// datapath. It accepts one block per upstream handshake and pulses sr_load.
// It then steps the register with sr_shift while presenting WORDS words
// downstream under a valid/ready handshake. Blocks can run back-to-back with
// no bubble. The controller also supports a synchronous flush and counts
// completed blocks.

module aes_block_serializer_ctrl #(
   parameter int WORDS = 4,
   parameter int IDX_W = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             blk_valid_in,
   output logic             blk_ready_out,
   output logic             sr_load,
   output logic             sr_shift,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             word_last,
   output logic [IDX_W-1:0] word_idx,
   input  logic             flush,
   output logic             busy,
   output logic [CNT_W-1:0] blk_count
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] word_idx_q, word_idx_d;
   logic [CNT_W-1:0] blk_count_q, blk_count_d;

   logic at_last;
   logic word_hs;

   assign at_last = (word_idx_q == IDX_W'(WORDS - 1));
   assign word_hs = (state_q == EMIT) && word_ready;

   // State, word index and block counter registers; reset clears all three
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         word_idx_q  <= '0;
         blk_count_q <= '0;
      end else begin
         state_q     <= state_d;
         word_idx_q  <= word_idx_d;
         blk_count_q <= blk_count_d;
      end
   end

   // Next state: flush drops the block in flight, last-word handshake counts it
   always_comb begin
      state_d     = state_q;
      word_idx_d  = word_idx_q;
      blk_count_d = blk_count_q;
      if (flush) begin
         state_d    = IDLE;
         word_idx_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (blk_valid_in) begin
                  state_d    = EMIT;
                  word_idx_d = '0;
               end
            end
            EMIT: begin
               if (word_hs) begin
                  if (at_last) begin
                     blk_count_d = blk_count_q + 1'b1;
                     word_idx_d  = '0;
                     state_d     = blk_valid_in ? EMIT : IDLE;
                  end else begin
                     word_idx_d = word_idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d    = IDLE;
               word_idx_d = '0;
            end
         endcase
      end
   end

   // Strobes and handshake outputs; everything is held low while reset is high
   always_comb begin
      blk_ready_out = 1'b0;
      sr_load       = 1'b0;
      sr_shift      = 1'b0;
      word_valid    = 1'b0;
      word_last     = 1'b0;
      busy          = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               blk_ready_out = !flush;
               sr_load       = blk_valid_in && !flush;
            end
            EMIT: begin
               word_valid = 1'b1;
               busy       = 1'b1;
               word_last  = at_last;
               if (word_hs && !flush) begin
                  if (at_last) begin
                     blk_ready_out = 1'b1;
                     sr_load       = blk_valid_in;
                  end else begin
                     sr_shift = 1'b1;
                  end
               end
            end
            default: begin
               blk_ready_out = 1'b0;
            end
         endcase
      end
   end

   assign word_idx  = word_idx_q;
   assign blk_count = blk_count_q;

endmodule

// File: doc/aes_block_serializer_ctrl.md
Name: aes_block_serializer_ctrl

Overview:
- Sequencing controller for the 128-to-32 output shift register in the AES128 datapath.
- Accepts one 128-bit block per valid/ready handshake and pulses the register's load strobe.
- Then steps the register with shift strobes, presenting WORDS words downstream under a 32-bit valid/ready handshake with index and last flags.
- Supports back-to-back blocks, downstream backpressure, a synchronous flush, and a completed-block counter.

Parameters:
- WORDS, 4, number of 32-bit words per block; must be at least 2.
- IDX_W, 2, width of the word index; equals clog2(WORDS).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- blk_valid_in  input  1  upstream has a 128-bit block on the shared data bus.
- blk_ready_out  output  1  controller accepts a block this cycle.
- sr_load  output  1  load strobe to the shift register; captures data_in on this edge.
- sr_shift  output  1  shift strobe to the shift register; advances data_out by one word.
- word_valid  output  1  shift-register data_out holds a valid word.
- word_ready  input  1  downstream accepts the word this cycle.
- word_last  output  1  current word is word WORDS-1 of the block.
- word_idx  output  IDX_W  index of the current word, 0 = most-significant word (data_in[127:96]).
- flush  input  1  synchronous abort of the block in flight.
- busy  output  1  a block is being emitted.
- blk_count  output  CNT_W  number of fully emitted blocks; wraps modulo 2^CNT_W.

Behaviour:
- Shift-register contract:
  - Load on edge N makes word 0 visible on data_out from cycle N+1.
  - Each sr_shift edge exposes the next lower word.
  - Load has priority over shift inside the register; this controller never asserts both.
- States are IDLE and EMIT; state, word_idx and blk_count are registered.
- Reset (reset=1 at an edge):
  - State goes to IDLE, word_idx=0, blk_count=0.
  - While reset is high, all combinational outputs are forced to 0: blk_ready_out, sr_load, sr_shift, word_valid, word_last and busy.
  - Reset mid-block discards the block with no strobes issued.
- IDLE:
  - blk_ready_out=1, word_valid=0, busy=0.
  - sr_load = blk_valid_in & blk_ready_out, combinational in the same cycle.
  - On accept, go to EMIT with word_idx=0.
- EMIT:
  - word_valid=1, busy=1, word_last = (word_idx==WORDS-1).
  - Handshake fires when word_valid & word_ready.
  - Handshake with a non-last word: sr_shift=1 and word_idx increments.
  - Handshake with the last word: blk_count increments and word_idx returns to 0.
    - If blk_valid_in=1 in the same cycle, blk_ready_out=1, sr_load=1, and the state stays EMIT (zero-bubble back-to-back).
    - Otherwise the state goes to IDLE.
  - blk_ready_out = word_valid & word_ready & word_last. It is never 1 in EMIT otherwise.
  - word_ready=0 holds the state, word_idx and strobes low; word_valid stays 1 (no drop of valid under backpressure).
- flush:
  - Takes effect at the edge: IDLE, word_idx=0, blk_count unchanged.
  - During a flush cycle, blk_ready_out, sr_load and sr_shift are 0; word_valid follows the state.
  - A last-word handshake in a flush cycle does not count the block.
  - reset has priority over flush.
- Throughput and latency:
  - One word per cycle under continuous ready.
  - Steady-state throughput is one block per WORDS cycles.
  - First word_valid appears the cycle after acceptance.
- sr_load and sr_shift are never high together and never high while reset=1.

Test Plan:
- Reset, then one block 128'h00112233_44556677_8899AABB_CCDDEEFF with word_ready=1:
  - sr_load pulses 1 cycle.
  - Words 00112233, 44556677, 8899AABB, CCDDEEFF appear on 4 consecutive cycles, idx 0..3, word_last only on CCDDEEFF.
  - Exactly 3 sr_shift pulses; blk_count=1; return to IDLE.
- Backpressure: word_ready low for 3 cycles on idx 1 → word_valid stays 1, idx stays 1, data_out stays 44556677, no sr_shift; the block completes afterwards in order.
- Back-to-back: blk_valid_in held high with two blocks and word_ready=1 → second sr_load coincides with the first block's last-word handshake; 8 words in 8 consecutive cycles; blk_count=2; busy never drops.
- flush asserted at idx 2 → next cycle is IDLE, word_valid=0, blk_count unchanged; the next block starts at idx 0 with correct words.
- reset asserted mid-EMIT at idx 1 → next cycle all outputs are 0, blk_count=0; after release blk_ready_out=1.
- Counter wrap with CNT_W=2: emit 5 blocks → blk_count reads 1,2,3,0,1.
